// File: rtl/timerio.sv
// timerio: 16-bit programmable interval timer on the 6801 bus.
// A prescaled down-counter that raises a level interrupt on underflow,
// with optional auto-reload and a coherent two-byte count snapshot.
module timerio #(
  parameter logic [7:0]  PRESCALE_RESET = 8'd0,
  parameter logic [15:0] RELOAD_RESET   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       ovf_pulse
);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_STAT  = 3'd1;
  localparam logic [2:0] A_RLD_H = 3'd2;
  localparam logic [2:0] A_RLD_L = 3'd3;
  localparam logic [2:0] A_CNT_H = 3'd4;
  localparam logic [2:0] A_CNT_L = 3'd5;
  localparam logic [2:0] A_PRES  = 3'd6;

  // Per-register strobes decoded from one bus cycle
  typedef struct packed {
    logic ctrl;
    logic stat;
    logic rld_h;
    logic rld_l;
    logic pres;
    logic cnt_h_rd;
  } bus_dec_t;

  // EN is the state itself: RUN means enabled
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_nxt;
  logic        auto_q, ie_q, ovf_q;
  logic [15:0] count_q, count_nxt;
  logic [15:0] reload_q, reload_nxt;
  logic [7:0]  hold_q, shadow_q, pres_q;
  logic [7:0]  pc_q, pc_nxt;
  logic        tick, underflow, en;
  bus_dec_t    dec;

  assign en = (state_q == S_RUN);

  // Bus decode: writes are cs & !rw, only the COUNT_H read has a side effect
  always_comb begin
    dec          = '0;
    dec.ctrl     = cs && !rw && (AD == A_CTRL);
    dec.stat     = cs && !rw && (AD == A_STAT);
    dec.rld_h    = cs && !rw && (AD == A_RLD_H);
    dec.rld_l    = cs && !rw && (AD == A_RLD_L);
    dec.pres     = cs && !rw && (AD == A_PRES);
    dec.cnt_h_rd = cs &&  rw && (AD == A_CNT_H);
  end

  // RELOAD as it will be after this edge, so a same-cycle auto-reload sees a fresh commit
  always_comb begin
    reload_nxt = reload_q;
    if (dec.rld_l) reload_nxt = {hold_q, DI};
  end

  // Timer FSM: LOAD is the CTRL write that turns EN on; a stop write beats a tick
  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    pc_nxt    = pc_q;
    tick      = 1'b0;
    underflow = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dec.ctrl && DI[0]) begin
          state_nxt = S_RUN;
          count_nxt = reload_q;
          pc_nxt    = 8'd0;
        end
      end
      S_RUN: begin
        if (dec.ctrl && !DI[0]) begin
          state_nxt = S_IDLE;
        end else begin
          tick   = (pc_q == pres_q);
          pc_nxt = tick ? 8'd0 : pc_q + 8'd1;
          if (tick) begin
            if (count_q != 16'd0) begin
              count_nxt = count_q - 16'd1;
            end else begin
              underflow = 1'b1;
              if (auto_q) count_nxt = reload_nxt;
              else        state_nxt = S_IDLE;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, count and prescaler registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= 16'd0;
      pc_q    <= 8'd0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      pc_q    <= pc_nxt;
    end
  end

  // Control bits: AUTO/IE follow every CTRL write, EN is handled by the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_q <= 1'b0;
      ie_q   <= 1'b0;
    end else if (dec.ctrl) begin
      auto_q <= DI[1];
      ie_q   <= DI[2];
    end
  end

  // Overflow flag: underflow set has priority over a write-1-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    ovf_q <= 1'b0;
    else if (underflow)          ovf_q <= 1'b1;
    else if (dec.stat && DI[0])  ovf_q <= 1'b0;
  end

  // RELOAD is committed as a pair through the holding byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q   <= 8'd0;
      reload_q <= RELOAD_RESET;
    end else begin
      if (dec.rld_h) hold_q <= DI;
      reload_q <= reload_nxt;
    end
  end

  // Prescale compare value; a mid-run change applies at the next compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pres_q <= PRESCALE_RESET;
    else if (dec.pres) pres_q <= DI;
  end

  // Low-byte snapshot taken on the COUNT_H read cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              shadow_q <= 8'd0;
    else if (dec.cnt_h_rd) shadow_q <= count_q[7:0];
  end

  // Read mux, combinational from AD
  always_comb begin
    DO = 8'h00;
    case (AD)
      A_CTRL:  DO = {5'b0, ie_q, auto_q, en};
      A_STAT:  DO = {6'b0, en, ovf_q};
      A_RLD_H: DO = reload_q[15:8];
      A_RLD_L: DO = reload_q[7:0];
      A_CNT_H: DO = count_q[15:8];
      A_CNT_L: DO = shadow_q;
      A_PRES:  DO = pres_q;
      default: DO = 8'h00;
    endcase
  end

  assign irq       = ovf_q & ie_q;
  assign ovf_pulse = underflow;

endmodule

// File: doc/timerio.md
Name: timerio

Overview:
- Memory-mapped 16-bit programmable interval timer on the 6801 system bus, decoded at the free DS1 slot ($E620, 8 registers, AD[2:0]).
- Down-counts on a programmable prescaled tick of sys_clk and raises a level interrupt on underflow.
- irq is ORed into sys_irq alongside simpleio/uartio.
- Gives the monitor and OS a periodic tick without software delay loops.

Parameters:
PRESCALE_RESET, 8'd0, reset value of PRESCALE register (tick = clk / (PRESCALE+1))
RELOAD_RESET, 16'hFFFF, reset value of RELOAD register

Ports:
clk  input  1  system clock (sys_clk)
rst  input  1  asynchronous reset, active-low
irq  output 1  level interrupt = OVF & IE
AD  input  3  register select
DI  input  8  CPU write data
DO  output 8  read data, combinational from AD
rw  input  1  1 = read, 0 = write
cs  input  1  chip select, already qualified with vma; one bus cycle = one clk
ovf_pulse  output 1  one-clk pulse on every underflow, for chaining or debug

Behaviour:
- Register map:
  - 0 CTRL (rw): bit0 EN, bit1 AUTO (auto-reload), bit2 IE; bits7:3 read 0.
  - 1 STAT: bit0 OVF, bit1 RUN (=EN). Writing 1 to bit0 clears OVF; writing 0 has no effect.
  - 2 RELOAD_H (rw): write goes to a holding byte; read returns committed RELOAD[15:8].
  - 3 RELOAD_L (rw): write commits {hold, DI} to RELOAD in the same edge.
  - 4 COUNT_H (r): returns COUNT[15:8]; the same read cycle latches COUNT[7:0] into a shadow.
  - 5 COUNT_L (r): returns the shadow.
  - 6 PRESCALE (rw).
  - 7 reads 8'h00; writes ignored.
- Write strobe is cs & !rw, sampled at posedge clk. Reads have no side effects except the COUNT_H shadow latch.
- Reset (rst=0, async), all registers:
  - CTRL=0, OVF=0, COUNT=0, shadow=0, hold=0, prescale counter=0.
  - RELOAD=RELOAD_RESET, PRESCALE=PRESCALE_RESET.
  - Outputs: irq=0, ovf_pulse=0.
  - Reset mid-count aborts immediately; there is no pending state.
- Prescaler:
  - 8-bit up counter PC, active only while EN=1.
  - When PC==PRESCALE: tick=1 and PC<=0; otherwise PC<=PC+1.
  - PRESCALE=0 gives a tick every clk.
- States:
  - IDLE (EN=0): COUNT holds.
  - LOAD: the single cycle on which a CTRL write sets EN from 0 to 1. COUNT<=RELOAD, PC<=0, no tick that cycle.
  - RUN (EN=1): on tick, if COUNT!=0 then COUNT<=COUNT-1.
- Underflow, on tick with COUNT==0:
  - OVF<=1 and ovf_pulse=1 for that cycle.
  - If AUTO=1: COUNT<=RELOAD and remain RUN.
  - If AUTO=0: EN<=0 (one-shot), COUNT stays 0, back to IDLE.
- Period with AUTO=1 is (RELOAD+1)*(PRESCALE+1) clks.
- A CTRL write with EN=1 while already running does not reload. It only updates AUTO/IE.
- A CTRL write with EN=0 stops immediately; COUNT and OVF are held.
- Simultaneous events:
  - Underflow and OVF-clear write in the same cycle: set wins, OVF=1.
  - RELOAD_L commit and an auto-reload in the same cycle: the new RELOAD value is loaded.
  - CTRL write clearing EN on a tick cycle: stop wins, no decrement and no OVF.
  - PRESCALE write mid-run takes effect on the next compare. If PC > new PRESCALE, PC wraps 255->0 naturally.
- irq is combinational (OVF & IE). Clearing IE deasserts irq without clearing OVF.
- COUNT_H/L reads give a coherent 16-bit snapshot provided COUNT_H is read first.

Test Plan:
- Reset with rst=0 mid-run -> DO(CTRL)=00, DO(STAT)=00, irq=0, RELOAD reads FFFF, COUNT=0000.
- RELOAD=0003, PRESCALE=00, CTRL=07 -> ovf_pulse every 4 clks after LOAD; OVF=1 and irq=1 at the first underflow; write STAT=01 clears irq.
- RELOAD=0002, PRESCALE=02, CTRL=01 (one-shot) -> single ovf_pulse 9 clks after LOAD; STAT reads 01 (RUN=0); COUNT=0000 thereafter.
- RELOAD=1234, EN set, read COUNT_H then COUNT_L several clks later -> the 16-bit value equals the counter at the COUNT_H read cycle, not the later value.
- Force the STAT=01 write on the same cycle as an underflow -> OVF stays 1, irq stays 1 (IE=1).
- Write RELOAD_H=00 only, run with AUTO -> reload value unchanged (FFFF) until RELOAD_L is written; then RELOAD_L=05 gives a 6-clk period from the next reload.
